// File: rtl/mem_access_pkg.sv
// Shared types and widths for the MEM-stage data-memory access block.
package mem_access_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access.sv
// MEM stage: issues one data-memory request per load/store, stalls the front of the
// pipeline until the memory acks, and feeds the MEM/WB register.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  op_mem_read_mem,
  input  logic                  op_mem_write_mem,
  input  logic                  op_reg_write_mem,
  input  logic                  op_reg_write_address_mem,
  input  logic                  op_res_mem,
  input  logic [REG_ADDR_W-1:0] rs_mem,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic [DATA_W-1:0]     alu_result_mem,
  input  logic [DATA_W-1:0]     store_data_mem,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  stall_mem,
  output logic                  op_reg_write_out,
  output logic                  op_reg_write_address_out,
  output logic                  op_res_out,
  output logic [REG_ADDR_W-1:0] rs_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [DATA_W-1:0]     data_register_out,
  output logic [DATA_W-1:0]     memory_data_register_out
);

  state_e              state_q, state_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [DATA_W-1:0]   load_buf_q, load_buf_d;
  logic                mem_op;

  assign mem_op = op_mem_read_mem | op_mem_write_mem;

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    load_buf_d   = load_buf_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d      = BUSY;
          dmem_req_d   = 1'b1;
          dmem_we_d    = op_mem_write_mem;
          dmem_addr_d  = alu_result_mem;
          dmem_wdata_d = store_data_mem;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d    = DONE;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          // dmem_we_q still reflects the op being completed
          if (!dmem_we_q) load_buf_d = dmem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      load_buf_q   <= '0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      load_buf_q   <= load_buf_d;
    end
  end

  // Stall covers the issuing IDLE cycle plus every BUSY cycle; never while in reset.
  assign stall_mem = !reset && (((state_q == IDLE) && mem_op) || (state_q == BUSY));

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;

  assign op_reg_write_out         = op_reg_write_mem & ~stall_mem;
  assign op_res_out               = op_res_mem & ~stall_mem;
  assign op_reg_write_address_out = op_reg_write_address_mem;
  assign rs_out                   = rs_mem;
  assign rd_out                   = rd_mem;
  assign data_register_out        = alu_result_mem;
  assign memory_data_register_out = load_buf_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: pass-through vector table plus scoreboarded
// load/store sequences covering ack latency, stray acks, write priority and reset.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_mem_read_mem = 1'b0, op_mem_write_mem = 1'b0;
  logic        op_reg_write_mem = 1'b0, op_reg_write_address_mem = 1'b0, op_res_mem = 1'b0;
  logic [2:0]  rs_mem = '0, rd_mem = '0;
  logic [15:0] alu_result_mem = '0, store_data_mem = '0;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        stall_mem;
  logic        op_reg_write_out, op_reg_write_address_out, op_res_out;
  logic [2:0]  rs_out, rd_out;
  logic [15:0] data_register_out, memory_data_register_out;

  mem_access dut (
    .clock(clock), .reset(reset),
    .op_mem_read_mem(op_mem_read_mem), .op_mem_write_mem(op_mem_write_mem),
    .op_reg_write_mem(op_reg_write_mem), .op_reg_write_address_mem(op_reg_write_address_mem),
    .op_res_mem(op_res_mem), .rs_mem(rs_mem), .rd_mem(rd_mem),
    .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .op_reg_write_out(op_reg_write_out), .op_reg_write_address_out(op_reg_write_address_out),
    .op_res_out(op_res_out), .rs_out(rs_out), .rd_out(rd_out),
    .data_register_out(data_register_out), .memory_data_register_out(memory_data_register_out)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_buf;
  } txn_t;
  txn_t sb_q[$];
  logic [15:0] model_buf = '0;

  typedef struct {
    logic        rw, rwa, res;
    logic [2:0]  rs, rd;
    logic [15:0] alu;
    logic        exp_rw, exp_rwa, exp_res;
    logic [15:0] exp_data;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ops();
    op_mem_read_mem  = 1'b0;
    op_mem_write_mem = 1'b0;
    op_reg_write_mem = 1'b0;
    op_res_mem       = 1'b0;
  endtask

  // Issues one op from IDLE and follows it through BUSY and DONE back to IDLE.
  task automatic do_op(input string tag, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input int delay, input logic [15:0] rdata, input logic stray_done);
    txn_t t;
    txn_t got;
    int   stalls;
    stalls = 0;
    op_mem_read_mem  = rd;
    op_mem_write_mem = wr;
    op_reg_write_mem = rd & ~wr;
    op_res_mem       = 1'b1;
    alu_result_mem   = addr;
    store_data_mem   = wd;
    dmem_ack         = 1'b0;
    if (!wr) model_buf = rdata;
    t.we = wr; t.addr = addr; t.wdata = wd; t.exp_buf = model_buf;
    sb_q.push_back(t);
    #1;
    if (stall_mem) stalls++;
    check({tag, ".issue_rw_bubble"}, 16'(op_reg_write_out), 16'h0);
    check({tag, ".issue_req_low"}, 16'(dmem_req), 16'h0);
    tick();
    check({tag, ".req_rise"}, 16'(dmem_req), 16'h1);
    if (dmem_req && sb_q.size() > 0) got = sb_q.pop_front();
    else got = t;
    // Scramble the stage inputs to prove the request is held by registers.
    alu_result_mem = ~addr;
    store_data_mem = ~wd;
    for (int i = 0; i <= delay; i++) begin
      if (stall_mem) stalls++;
      check({tag, ".busy_req"}, 16'(dmem_req), 16'h1);
      check({tag, ".busy_we"}, 16'(dmem_we), 16'(got.we));
      check({tag, ".busy_addr"}, dmem_addr, got.addr);
      check({tag, ".busy_wdata"}, dmem_wdata, got.wdata);
      check({tag, ".busy_res_bubble"}, 16'(op_res_out), 16'h0);
      dmem_ack   = (i == delay);
      dmem_rdata = (i == delay) ? rdata : 16'($urandom);
      if (i == delay) begin
        alu_result_mem = addr;
        store_data_mem = wd;
      end
      tick();
    end
    dmem_ack = 1'b0;
    check({tag, ".done_stall"}, 16'(stall_mem), 16'h0);
    check({tag, ".done_req"}, 16'(dmem_req), 16'h0);
    check({tag, ".done_we"}, 16'(dmem_we), 16'h0);
    check({tag, ".done_buf"}, memory_data_register_out, got.exp_buf);
    check({tag, ".done_rw"}, 16'(op_reg_write_out), 16'(rd & ~wr));
    check({tag, ".done_res"}, 16'(op_res_out), 16'h1);
    check({tag, ".done_data_reg"}, data_register_out, addr);
    check({tag, ".stall_cycles"}, 16'(stalls), 16'(delay + 2));
    if (stray_done) begin
      dmem_ack   = 1'b1;
      dmem_rdata = 16'hDEAD;
    end
    tick();
    dmem_ack = 1'b0;
    clear_ops();
    if (stray_done) begin
      #1;
      check({tag, ".stray_done_req"}, 16'(dmem_req), 16'h0);
      check({tag, ".stray_done_stall"}, 16'(stall_mem), 16'h0);
      check({tag, ".stray_done_buf"}, memory_data_register_out, model_buf);
    end
    $display("txn %s we=%0b addr=%h wdata=%h delay=%0d buf=%h", tag, got.we, got.addr,
             got.wdata, delay, memory_data_register_out);
  endtask

  initial begin
    // Reset with a pending memory op: stall must stay low and registers clear.
    reset = 1'b1;
    op_mem_read_mem = 1'b1; op_mem_write_mem = 1'b1;
    alu_result_mem = 16'hFFFF; store_data_mem = 16'hFFFF;
    #1;
    check("reset_stall", 16'(stall_mem), 16'h0);
    tick();
    tick();
    check("reset_req", 16'(dmem_req), 16'h0);
    check("reset_we", 16'(dmem_we), 16'h0);
    check("reset_addr", dmem_addr, 16'h0);
    check("reset_wdata", dmem_wdata, 16'h0);
    check("reset_buf", memory_data_register_out, 16'h0);
    clear_ops();
    reset = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 16'h0042, 1'b1, 1'b0, 1'b0, 16'h0042};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 3'd7, 3'd0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'hFFFF};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 3'd5, 3'd3, 16'h8001, 1'b1, 1'b1, 1'b1, 16'h8001};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd6, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      op_reg_write_mem = vecs[i].rw;
      op_reg_write_address_mem = vecs[i].rwa;
      op_res_mem = vecs[i].res;
      rs_mem = vecs[i].rs;
      rd_mem = vecs[i].rd;
      alu_result_mem = vecs[i].alu;
      #1;
      check("vec_stall", 16'(stall_mem), 16'h0);
      check("vec_req", 16'(dmem_req), 16'h0);
      check("vec_rw", 16'(op_reg_write_out), 16'(vecs[i].exp_rw));
      check("vec_rwa", 16'(op_reg_write_address_out), 16'(vecs[i].exp_rwa));
      check("vec_res", 16'(op_res_out), 16'(vecs[i].exp_res));
      check("vec_rs", 16'(rs_out), 16'(vecs[i].rs));
      check("vec_rd", 16'(rd_out), 16'(vecs[i].rd));
      check("vec_data_reg", data_register_out, vecs[i].exp_data);
      tick();
      check("vec_stall_next", 16'(stall_mem), 16'h0);
      check("vec_req_next", 16'(dmem_req), 16'h0);
      $display("txn vec%0d alu=%h data_reg=%h", i, vecs[i].alu, data_register_out);
    end
    op_reg_write_address_mem = 1'b0;
    clear_ops();

    do_op("load_beef", 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 1'b0);
    do_op("store_1234", 1'b0, 1'b1, 16'h0020, 16'h1234, 4, 16'h4321, 1'b1);

    // Stray ack while idle must not disturb anything.
    dmem_ack = 1'b1;
    dmem_rdata = 16'hCAFE;
    #1;
    check("stray_idle_stall", 16'(stall_mem), 16'h0);
    tick();
    dmem_ack = 1'b0;
    check("stray_idle_req", 16'(dmem_req), 16'h0);
    check("stray_idle_buf", memory_data_register_out, model_buf);
    $display("txn stray_idle buf=%h", memory_data_register_out);

    do_op("rw_both", 1'b1, 1'b1, 16'h0030, 16'h5555, 1, 16'h7777, 1'b0);

    // Reset in BUSY abandons the op; the late ack is ignored.
    op_mem_read_mem = 1'b1;
    alu_result_mem = 16'h0050;
    tick();
    check("rst_busy_req", 16'(dmem_req), 16'h1);
    reset = 1'b1;
    #1;
    check("rst_busy_stall", 16'(stall_mem), 16'h0);
    tick();
    reset = 1'b0;
    clear_ops();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h9999;
    model_buf = 16'h0000;
    #1;
    check("rst_after_req", 16'(dmem_req), 16'h0);
    check("rst_after_stall", 16'(stall_mem), 16'h0);
    tick();
    dmem_ack = 1'b0;
    check("rst_late_ack_req", 16'(dmem_req), 16'h0);
    check("rst_late_ack_buf", memory_data_register_out, model_buf);
    check("rst_late_ack_addr", dmem_addr, 16'h0);
    $display("txn reset_mid_busy buf=%h", memory_data_register_out);

    do_op("b2b_load", 1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'h0A0B, 1'b0);
    do_op("b2b_store", 1'b0, 1'b1, 16'h0044, 16'hA5A5, 0, 16'h1111, 1'b0);

    check("scoreboard_empty", 16'(sb_q.size()), 16'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
